tap_tms_driver: RTL and testbench
=================================

# tap_tms_driver

Host-side JTAG TMS sequencer that drives the TMS/TCK-enable pair consumed by the TAP controller. It accepts high-level commands (go to a stable TAP state, force Test-Logic-Reset, idle for N cycles), computes the shortest TMS walk through the 16-state IEEE 1149.1 TAP graph, and emits it one bit per clock. It keeps a mirror of the target TAP's state. It sits between the test-control logic and the TMS_Pad/GCLK_Pad gating of the TAP block.

## Interface
- CNT_W, 8, width of the RUNTEST idle-cycle count
- GCLK_Pad  in  1  clock; all logic on rising edge
- TRST_Pad  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  driver can accept a command (IDLE only)
- cmd_op  in  2  0=GOTO, 1=RESET, 2=RUNTEST, 3=NOP
- cmd_state  in  4  GOTO target, TAP encoding below
- cmd_count  in  CNT_W  RUNTEST idle count N
- TMS_Pad  out  1  registered TMS bit
- tck_en  out  1  high when TMS_Pad is a valid bit for the TAP to clock this cycle
- state_obs  out  4  mirrored TAP state after all bits emitted so far
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done for an illegal GOTO target

## Operation
- TAP encoding:
  - 0 TLR, 1 RTI, 2 SelDR, 3 CapDR, 4 ShDR, 5 Ex1DR, 6 PauseDR, 7 Ex2DR
  - 8 UpdDR, 9 SelIR, 10 CapIR, 11 ShIR, 12 Ex1IR, 13 PauseIR, 14 Ex2IR, 15 UpdIR
  - Transitions follow IEEE 1149.1 exactly.
- FSM states: IDLE, RESET5, WALK, HOLD, DONE.
- IDLE:
  - cmd_ready=1, tck_en=0, TMS_Pad=0.
  - A handshake (cmd_valid & cmd_ready) latches op/state/count.
- GOTO:
  - Legal targets are the stable states only: 0, 1, 4, 6, 11, 13.
  - Any other target goes straight to DONE with err=1 and no bits emitted.
  - If the target equals state_obs, go straight to DONE.
  - Otherwise enter WALK.
- WALK:
  - Each cycle emit the TMS bit whose successor has the strictly smaller shortest-path distance to the target.
  - On an equal distance, emit 0.
  - Routing is a combinational function of (state_obs, target).
  - Leave WALK when the successor equals the target.
- RESET: emit five consecutive 1s in RESET5, independent of state_obs. The mirror ends at TLR.
- RUNTEST:
  - WALK to RTI using the GOTO rules.
  - Then HOLD emits N bits of TMS=0.
  - N=0 skips HOLD.
- NOP: straight to DONE, no bits.
- DONE: done=1 for one cycle (plus err if flagged), then IDLE.
- state_obs updates one cycle after the bit is presented, to the successor of the presented bit. In DONE it equals the final state.
- Reset, including mid-command: next cycle all FSMs go to IDLE and the in-flight command is discarded.
  - Outputs: TMS_Pad=0, tck_en=0, state_obs=0 (TLR), cmd_ready=1, done=0, err=0.
  - The TAP is reset by the same TRST_Pad, so the mirror stays consistent.

## Timing
- Handshake in cycle t. First bit is valid on TMS_Pad with tck_en=1 in cycle t+1.
- A k-bit sequence occupies cycles t+1..t+k with tck_en continuously high; there are no gaps.
- done is in cycle t+k+1. cmd_ready is high again in cycle t+k+2.
- Zero-bit commands (NOP, GOTO to the current state, illegal target): done in t+1, cmd_ready in t+2.
- cmd_ready is low from t+1 until IDLE; cmd_valid in that window is ignored.
- Maximum walk length between any two states is bounded by the TAP graph (≤ 7 bits for stable targets).
- HOLD length is exactly N for N up to 2^CNT_W−1. The counter does not wrap.
- TMS_Pad and tck_en are driven straight from flops, with no combinational path from cmd_*.

## Test plan
- Reset, then GOTO 4 (ShDR) → TMS 0,1,0,0 in t+1..t+4, tck_en high those 4 cycles, done at t+5, state_obs=4.
- From ShDR, RESET → TMS 1,1,1,1,1, state_obs=0 at done; then GOTO 11 (ShIR) via RTI: after GOTO 1 (TMS 0), GOTO 11 → TMS 1,1,0,0.
- From ShIR, GOTO 6 (PauseDR) → TMS 1,1,1,0,1,0 (6 bits), state_obs=6.
- From PauseDR, RUNTEST N=3 → TMS 1,1,0 then 0,0,0, done at t+7, state_obs=1.
- GOTO 3 (CapDR) and GOTO equal to the current state → no tck_en; done at t+1 with err=1 and err=0 respectively; NOP identical with err=0.
- TRST_Pad asserted in the 3rd cycle of a 6-bit walk → next cycle tck_en=0, TMS_Pad=0, state_obs=0, cmd_ready=1, no done; a following GOTO 4 emits 0,1,0,0.

Source files
------------

// File: rtl/tap_tms_driver.sv
// Host-side JTAG TMS sequencer. Accepts GOTO / RESET / RUNTEST / NOP commands,
// walks the IEEE 1149.1 TAP graph along a shortest path one TMS bit per clock,
// and keeps a mirror of the target TAP state in state_obs.
module tap_tms_driver #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             GCLK_Pad,
  input  logic             TRST_Pad,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_state,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             TMS_Pad,
  output logic             tck_en,
  output logic [3:0]       state_obs,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {StIdle, StReset5, StWalk, StHold, StDone} fsm_e;

  localparam logic [1:0] OpGoto    = 2'd0;
  localparam logic [1:0] OpReset   = 2'd1;
  localparam logic [1:0] OpRuntest = 2'd2;
  localparam logic [1:0] OpNop     = 2'd3;

  localparam logic [3:0] TapRti = 4'd1;

  // IEEE 1149.1 successor of TAP state s when TMS = tms.
  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    logic [3:0] n;
    n = s;
    case (s)
      4'd0:  n = tms ? 4'd0  : 4'd1;
      4'd1:  n = tms ? 4'd2  : 4'd1;
      4'd2:  n = tms ? 4'd9  : 4'd3;
      4'd3:  n = tms ? 4'd5  : 4'd4;
      4'd4:  n = tms ? 4'd5  : 4'd4;
      4'd5:  n = tms ? 4'd8  : 4'd6;
      4'd6:  n = tms ? 4'd7  : 4'd6;
      4'd7:  n = tms ? 4'd8  : 4'd4;
      4'd8:  n = tms ? 4'd2  : 4'd1;
      4'd9:  n = tms ? 4'd0  : 4'd10;
      4'd10: n = tms ? 4'd12 : 4'd11;
      4'd11: n = tms ? 4'd12 : 4'd11;
      4'd12: n = tms ? 4'd15 : 4'd13;
      4'd13: n = tms ? 4'd14 : 4'd13;
      4'd14: n = tms ? 4'd15 : 4'd11;
      default: n = tms ? 4'd2 : 4'd1;
    endcase
    return n;
  endfunction

  // Shortest-path length from -> to, found by growing the reachable set one step at a time.
  function automatic logic [4:0] tap_dist(input logic [3:0] from, input logic [3:0] to);
    logic [15:0] reach;
    logic [15:0] grow;
    logic [4:0]  d;
    reach = 16'(1) << from;
    d     = 5'd31;
    for (int k = 0; k < 16; k++) begin
      if (reach[to] && d == 5'd31) d = 5'(k);
      grow = reach;
      for (int i = 0; i < 16; i++) begin
        if (reach[i]) begin
          grow[tap_next(4'(i), 1'b0)] = 1'b1;
          grow[tap_next(4'(i), 1'b1)] = 1'b1;
        end
      end
      reach = grow;
    end
    return d;
  endfunction

  // TMS=1 only if it strictly shortens the remaining path; ties resolve to 0.
  function automatic logic tap_route(input logic [3:0] pos, input logic [3:0] to);
    return tap_dist(tap_next(pos, 1'b1), to) < tap_dist(tap_next(pos, 1'b0), to);
  endfunction

  function automatic logic tap_stable(input logic [3:0] s);
    return s inside {4'd0, 4'd1, 4'd4, 4'd6, 4'd11, 4'd13};
  endfunction

  fsm_e             fsm_q, fsm_d;
  logic             tms_q, tms_d;
  logic             tck_q, tck_d;
  logic [3:0]       obs_q, obs_d;
  logic [1:0]       op_q, op_d;
  logic [3:0]       tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       rcnt_q, rcnt_d;
  logic             err_q, err_d;
  logic [3:0]       pos;

  // Next-state logic; pos is where the TAP will be once the bit now on TMS_Pad is clocked.
  always_comb begin
    fsm_d  = fsm_q;
    tms_d  = 1'b0;
    tck_d  = 1'b0;
    op_d   = op_q;
    tgt_d  = tgt_q;
    cnt_d  = cnt_q;
    rcnt_d = rcnt_q;
    err_d  = err_q;
    pos    = tck_q ? tap_next(obs_q, tms_q) : obs_q;
    obs_d  = pos;
    unique case (fsm_q)
      StIdle: begin
        err_d = 1'b0;
        if (cmd_valid) begin
          op_d  = cmd_op;
          tgt_d = (cmd_op == OpRuntest) ? TapRti : cmd_state;
          cnt_d = cmd_count;
          unique case (cmd_op)
            OpGoto: begin
              if (!tap_stable(cmd_state)) begin
                fsm_d = StDone;
                err_d = 1'b1;
              end else if (cmd_state == pos) begin
                fsm_d = StDone;
              end else begin
                fsm_d = StWalk;
                tck_d = 1'b1;
                tms_d = tap_route(pos, cmd_state);
              end
            end
            OpReset: begin
              fsm_d  = StReset5;
              tck_d  = 1'b1;
              tms_d  = 1'b1;
              rcnt_d = 3'd4;
            end
            OpRuntest: begin
              if (pos != TapRti) begin
                fsm_d = StWalk;
                tck_d = 1'b1;
                tms_d = tap_route(pos, TapRti);
              end else if (cmd_count == '0) begin
                fsm_d = StDone;
              end else begin
                fsm_d = StHold;
                tck_d = 1'b1;
                cnt_d = cmd_count - 1'b1;
              end
            end
            OpNop: fsm_d = StDone;
            default: fsm_d = StDone;
          endcase
        end
      end
      StWalk: begin
        if (pos == tgt_q) begin
          if (op_q == OpRuntest && cnt_q != '0) begin
            fsm_d = StHold;
            tck_d = 1'b1;
            cnt_d = cnt_q - 1'b1;
          end else begin
            fsm_d = StDone;
          end
        end else begin
          tck_d = 1'b1;
          tms_d = tap_route(pos, tgt_q);
        end
      end
      // cnt_q counts idle bits still to emit after the one currently presented.
      StHold: begin
        if (cnt_q == '0) begin
          fsm_d = StDone;
        end else begin
          tck_d = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      StReset5: begin
        if (rcnt_q == 3'd0) begin
          fsm_d = StDone;
        end else begin
          tck_d  = 1'b1;
          tms_d  = 1'b1;
          rcnt_d = rcnt_q - 3'd1;
        end
      end
      StDone: fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; the mirror returns to TLR with the TAP.
  always_ff @(posedge GCLK_Pad) begin
    if (TRST_Pad) begin
      fsm_q  <= StIdle;
      tms_q  <= 1'b0;
      tck_q  <= 1'b0;
      obs_q  <= 4'd0;
      op_q   <= OpNop;
      tgt_q  <= 4'd0;
      cnt_q  <= '0;
      rcnt_q <= 3'd0;
      err_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      tms_q  <= tms_d;
      tck_q  <= tck_d;
      obs_q  <= obs_d;
      op_q   <= op_d;
      tgt_q  <= tgt_d;
      cnt_q  <= cnt_d;
      rcnt_q <= rcnt_d;
      err_q  <= err_d;
    end
  end

  assign cmd_ready = (fsm_q == StIdle);
  assign done      = (fsm_q == StDone);
  assign err       = (fsm_q == StDone) && err_q;
  assign TMS_Pad   = tms_q;
  assign tck_en    = tck_q;
  assign state_obs = obs_q;

endmodule

// File: tb/tb_tap_tms_driver.sv
// Bench for tap_tms_driver: a graph/BFS model predicts every cycle's outputs,
// a negedge process compares them, and literal sequences pin the model.
module tb_tap_tms_driver;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          trst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [3:0]    cmd_state;
  logic [CW-1:0] cmd_count;
  logic          TMS_Pad;
  logic          tck_en;
  logic [3:0]    state_obs;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  tap_tms_driver #(.CNT_W(CW)) dut (
    .GCLK_Pad  (clk),
    .TRST_Pad  (trst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_state (cmd_state),
    .cmd_count (cmd_count),
    .TMS_Pad   (TMS_Pad),
    .tck_en    (tck_en),
    .state_obs (state_obs),
    .done      (done),
    .err       (err)
  );

  // TAP graph: successor on TMS=0 / TMS=1.
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  int exp_tms, exp_tck, exp_ready, exp_done, exp_err, exp_obs;

  int dd[16];
  int mbits[$];
  int m_err;
  int m_final;
  int m_obs = 0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle comparison against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("TMS_Pad", int'(TMS_Pad), exp_tms);
      chk("tck_en", int'(tck_en), exp_tck);
      chk("state_obs", int'(state_obs), exp_obs);
      chk("cmd_ready", int'(cmd_ready), exp_ready);
      chk("done", int'(done), exp_done);
      chk("err", int'(err), exp_err);
    end
  end

  // Reverse BFS: dd[s] = shortest distance from s to tgt.
  task automatic model_dist(input int tgt);
    int fr[$];
    int v;
    for (int i = 0; i < 16; i++) dd[i] = 99;
    dd[tgt] = 0;
    fr.push_back(tgt);
    while (fr.size() > 0) begin
      v = fr.pop_front();
      for (int u = 0; u < 16; u++) begin
        if ((nxt0[u] == v || nxt1[u] == v) && dd[u] == 99) begin
          dd[u] = dd[v] + 1;
          fr.push_back(u);
        end
      end
    end
  endtask

  task automatic model_walk(input int start, input int tgt);
    int s;
    int b;
    int g;
    model_dist(tgt);
    s = start;
    g = 0;
    while (s != tgt && g < 32) begin
      b = (dd[nxt1[s]] < dd[nxt0[s]]) ? 1 : 0;
      mbits.push_back(b);
      s = b ? nxt1[s] : nxt0[s];
      g++;
    end
  endtask

  task automatic model_cmd(input int op, input int st, input int n, input int start);
    int s;
    mbits.delete();
    m_err = 0;
    case (op)
      0: begin
        if (!(st inside {0, 1, 4, 6, 11, 13})) m_err = 1;
        else model_walk(start, st);
      end
      1: for (int i = 0; i < 5; i++) mbits.push_back(1);
      2: begin
        model_walk(start, 1);
        for (int i = 0; i < n; i++) mbits.push_back(0);
      end
      default: ;
    endcase
    s = start;
    foreach (mbits[j]) s = mbits[j] ? nxt1[s] : nxt0[s];
    m_final = s;
  endtask

  task automatic set_exp(input int tms, input int tck, input int obs, input int rdy,
                         input int dn, input int er);
    exp_tms   = tms;
    exp_tck   = tck;
    exp_obs   = obs;
    exp_ready = rdy;
    exp_done  = dn;
    exp_err   = er;
  endtask

  // lit_bits: expected TMS sequence MSB-first, zeros beyond the 16th bit.
  // abort_at>0: assert TRST during the abort_at-th bit cycle.
  task automatic run_cmd(input int op, input int st, input int n, input int lit_len,
                         input logic [15:0] lit_bits, input int lit_err, input int lit_final,
                         input int abort_at);
    int pin_ok;
    int eb;
    int s;
    model_cmd(op, st, n, m_obs);
    pin_ok = (mbits.size() == lit_len) ? 1 : 0;
    foreach (mbits[j]) begin
      eb = (j < 16) ? int'(lit_bits[15-j]) : 0;
      if (mbits[j] != eb) pin_ok = 0;
    end
    chk("model_len", mbits.size(), lit_len);
    chk("model_bits", pin_ok, 1);
    chk("model_err", m_err, lit_err);
    chk("model_final", m_final, lit_final);

    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_state = 4'(st);
    cmd_count = CW'(n);
    set_exp(0, 0, m_obs, 1, 0, 0);
    s = m_obs;
    foreach (mbits[j]) begin
      @(posedge clk); #1;
      // Busy-window commands must be ignored.
      cmd_valid = (abort_at == 0) ? 1'b1 : 1'b0;
      cmd_op    = 2'd1;
      cmd_state = 4'd0;
      set_exp(mbits[j], 1, s, 0, 0, 0);
      if (abort_at == j + 1) begin
        trst = 1'b1;
        @(posedge clk); #1;
        trst = 1'b0;
        set_exp(0, 0, 0, 1, 0, 0);
        m_obs = 0;
        @(posedge clk); #1;
        set_exp(0, 0, 0, 1, 0, 0);
        return;
      end
      s = mbits[j] ? nxt1[s] : nxt0[s];
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    set_exp(0, 0, m_final, 0, 1, m_err);
    @(posedge clk); #1;
    set_exp(0, 0, m_final, 1, 0, 0);
    m_obs = m_final;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    trst      = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd3;
    cmd_state = 4'd0;
    cmd_count = '0;
    @(posedge clk); #1;
    set_exp(0, 0, 0, 1, 0, 0);
    chk_en = 1'b1;
    @(posedge clk); #1;
    trst = 1'b0;

    run_cmd(0, 4, 0, 4, 16'b0100_0000_0000_0000, 0, 4, 0);   // GOTO ShDR
    run_cmd(1, 0, 0, 5, 16'b1111_1000_0000_0000, 0, 0, 0);   // RESET
    run_cmd(0, 1, 0, 1, 16'b0000_0000_0000_0000, 0, 1, 0);   // GOTO RTI
    run_cmd(0, 11, 0, 4, 16'b1100_0000_0000_0000, 0, 11, 0); // GOTO ShIR
    run_cmd(0, 6, 0, 6, 16'b1110_1000_0000_0000, 0, 6, 0);   // GOTO PauseDR
    run_cmd(2, 0, 3, 6, 16'b1100_0000_0000_0000, 0, 1, 0);   // RUNTEST 3
    run_cmd(0, 3, 0, 0, 16'b0000_0000_0000_0000, 1, 1, 0);   // illegal CapDR
    run_cmd(0, 1, 0, 0, 16'b0000_0000_0000_0000, 0, 1, 0);   // GOTO current
    run_cmd(3, 5, 7, 0, 16'b0000_0000_0000_0000, 0, 1, 0);   // NOP
    run_cmd(2, 9, 0, 0, 16'b0000_0000_0000_0000, 0, 1, 0);   // RUNTEST 0 at RTI
    run_cmd(2, 0, 255, 255, 16'b0000_0000_0000_0000, 0, 1, 0); // RUNTEST max
    run_cmd(0, 13, 0, 5, 16'b1101_0000_0000_0000, 0, 13, 0); // GOTO PauseIR
    run_cmd(2, 0, 2, 5, 16'b1100_0000_0000_0000, 0, 1, 0);   // RUNTEST 2
    run_cmd(0, 0, 0, 3, 16'b1110_0000_0000_0000, 0, 0, 0);   // GOTO TLR
    run_cmd(0, 11, 0, 5, 16'b0110_0000_0000_0000, 0, 11, 0); // TLR -> ShIR
    run_cmd(0, 6, 0, 6, 16'b1110_1000_0000_0000, 0, 6, 3);   // aborted walk
    run_cmd(0, 4, 0, 4, 16'b0100_0000_0000_0000, 0, 4, 0);   // GOTO ShDR after reset
    run_cmd(0, 15, 0, 0, 16'b0000_0000_0000_0000, 1, 4, 0);  // illegal UpdIR
    run_cmd(0, 4, 0, 0, 16'b0000_0000_0000_0000, 0, 4, 0);   // GOTO current

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
